seg595_num_disp: RTL and testbench

- Parametrised successor to the fixed 6-digit temperature display path.
- Accepts a binary magnitude, a sign and a decimal-point mask through a valid/busy handshake.
- Converts the value to BCD sequentially, with leading-zero blanking, a minus sign and overflow indication.
- Scans DIG_NUM digits and drives a 74HC595 chain serially. Any sensor controller in the board tops can feed it.

---
 rtl/seg595_num_disp_if.sv | 34 +++
 rtl/seg595_num_disp.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_seg595_num_disp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg595_num_disp_if.sv
// seg595_num_disp_if: load-side bus of seg595_num_disp (value, sign, dp mask, enable,
// valid/busy handshake). Optional macro SEG_BLINK_EN adds the per-digit blink mask.
interface seg595_num_disp_if #(
    parameter int unsigned DIG_NUM = 6,
    parameter int unsigned DATA_W  = 20
);
    logic [DATA_W-1:0]  data;
    logic               sign;
    logic [DIG_NUM-1:0] point;
    logic               seg_en;
    logic               data_valid;
    logic               busy;
`ifdef SEG_BLINK_EN
    logic [DIG_NUM-1:0] blink;

    modport master (
        output data, sign, point, seg_en, data_valid, blink,
        input  busy
    );
    modport slave (
        input  data, sign, point, seg_en, data_valid, blink,
        output busy
    );
`else
    modport master (
        output data, sign, point, seg_en, data_valid,
        input  busy
    );
    modport slave (
        input  data, sign, point, seg_en, data_valid,
        output busy
    );
`endif
endinterface

// File: rtl/seg595_num_disp.sv
// seg595_num_disp: binary magnitude -> BCD (double-dabble) -> 7-segment digits with
// leading-zero blanking, minus sign and overflow, scanned out to a 74HC595 chain.
// Optional macro SEG_BLINK_EN adds the blink mask input and the BLINK_CNT parameter.
module seg595_num_disp #(
    parameter int unsigned DIG_NUM        = 6,
    parameter int unsigned DATA_W         = 20,
    parameter int unsigned SCAN_CNT       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
`ifdef SEG_BLINK_EN
    ,
    parameter int unsigned BLINK_CNT      = 250
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    seg595_num_disp_if.slave bus,
    output logic             shcp,
    output logic             stcp,
    output logic             ds,
    output logic             oe
);

    // BCD digits needed for DATA_W bits, never fewer than the displayed digits
    localparam int unsigned BCD_RAW = (DATA_W * 3) / 10 + 1;
    localparam int unsigned BCD_N   = (BCD_RAW > DIG_NUM) ? BCD_RAW : DIG_NUM;
    localparam int unsigned BCD_W   = 4 * BCD_N;
    localparam int unsigned FRAME_W = 8 + DIG_NUM;
    localparam int unsigned DIG_W   = $clog2(DIG_NUM);
    localparam int unsigned SCAN_W  = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned FB_W    = $clog2(FRAME_W + 1);

    // Active-high {g,f,e,d,c,b,a} pattern of one decimal digit
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Load and conversion
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StConv, StDecode} conv_state_e;

    conv_state_e        state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [DIG_NUM-1:0] point_q, point_d;
    logic               buf_we;

    // Double-dabble add-3 correction on every BCD nibble
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next state: accept, DATA_W shift cycles, one decode cycle
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        point_d = point_q;
        buf_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.data_valid) begin
                    bin_d   = bus.data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    sign_d  = bus.sign;
                    point_d = bus.point;
                    state_d = StConv;
                end
            end
            StConv: begin
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                buf_we  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Conversion FSM registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            point_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            point_q <= point_d;
        end
    end

    assign bus.busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Blanking / sign / overflow decode into active-high digit patterns
    // ------------------------------------------------------------------
    int         hi_dig;
    int         hi_pt;
    int         lead;
    logic       ovf;
    logic [7:0] dec_seg [DIG_NUM];

    // lead = highest digit that must be shown (value or decimal point)
    always_comb begin
        hi_dig = 0;
        hi_pt  = 0;
        ovf    = 1'b0;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                hi_dig = i;
                if (i >= int'(DIG_NUM)) begin
                    ovf = 1'b1;
                end
            end
        end
        for (int i = 0; i < int'(DIG_NUM); i++) begin
            if (point_q[i]) begin
                hi_pt = i;
            end
        end
        lead = (hi_dig > hi_pt) ? hi_dig : hi_pt;
        // The minus sign needs one more digit to the left
        if (sign_q && (lead + 1 >= int'(DIG_NUM))) begin
            ovf = 1'b1;
        end
        for (int i = 0; i < int'(DIG_NUM); i++) begin
            if (ovf) begin
                dec_seg[i] = 8'h40;
            end else if (i <= lead) begin
                dec_seg[i] = {point_q[i], seg_of(bcd_q[4*i +: 4])};
            end else if (sign_q && (i == lead + 1)) begin
                dec_seg[i] = {point_q[i], 7'h40};
            end else begin
                dec_seg[i] = {point_q[i], 7'h00};
            end
        end
    end

    logic [7:0] dbuf_q [DIG_NUM];

    // Display buffer, written once per conversion
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(DIG_NUM); i++) begin
                dbuf_q[i] <= 8'h00;
            end
        end else if (buf_we) begin
            dbuf_q <= dec_seg;
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_q;
    logic [DIG_W-1:0]  dig_q, dig_nxt, frame_dig;
    logic              first_q;
    logic              scan_wrap;
    logic              frame_start;

    assign scan_wrap   = (scan_q == SCAN_W'(SCAN_CNT - 1));
    assign dig_nxt     = (dig_q == DIG_W'(DIG_NUM - 1)) ? '0 : dig_q + DIG_W'(1);
    assign frame_start = first_q | scan_wrap;

    // Scan counter, digit index and the one-shot first frame after reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_q  <= '0;
            dig_q   <= '0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (scan_wrap) begin
                scan_q <= '0;
                dig_q  <= dig_nxt;
            end else begin
                scan_q <= scan_q + SCAN_W'(1);
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BL_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

    logic [BL_W-1:0] round_q;
    logic            blink_ph_q;
    logic            round_end;

    assign round_end = scan_wrap && (dig_q == DIG_W'(DIG_NUM - 1));

    // Blink phase toggles every BLINK_CNT complete scan rounds
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            round_q    <= '0;
            blink_ph_q <= 1'b0;
        end else if (round_end) begin
            if (round_q == BL_W'(BLINK_CNT - 1)) begin
                round_q    <= '0;
                blink_ph_q <= ~blink_ph_q;
            end else begin
                round_q <= round_q + BL_W'(1);
            end
        end
    end
`endif

    logic [DIG_NUM-1:0] frame_sel;
    logic [7:0]         frame_seg;

    // Frame content for the digit being started: one-hot select plus segment byte
    always_comb begin
        frame_dig            = first_q ? dig_q : dig_nxt;
        frame_sel            = '0;
        frame_sel[frame_dig] = 1'b1;
        frame_seg            = dbuf_q[frame_dig];
`ifdef SEG_BLINK_EN
        if (blink_ph_q && bus.blink[frame_dig]) begin
            frame_seg = 8'h00;
        end
`endif
        if (SEG_ACTIVE_LOW) begin
            frame_seg = ~frame_seg;
        end
    end

    // ------------------------------------------------------------------
    // 74HC595 shift engine: FRAME_W bit periods plus one latch period,
    // four cycles each; ds is the shift register MSB so it moves at phase 0
    // ------------------------------------------------------------------
    logic               act_q, act_d;
    logic [1:0]         ph_q, ph_d;
    logic [FB_W-1:0]    fb_q, fb_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               shcp_q, shcp_d;
    logic               stcp_q, stcp_d;
    logic               seen_q;
    logic               oe_q;

    // Shift engine next state and registered strobe values
    always_comb begin
        act_d = act_q;
        ph_d  = ph_q;
        fb_d  = fb_q;
        sh_d  = sh_q;
        if (frame_start) begin
            act_d = 1'b1;
            ph_d  = 2'd0;
            fb_d  = '0;
            sh_d  = {frame_sel, frame_seg};
        end else if (act_q) begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
                if (fb_q == FB_W'(FRAME_W)) begin
                    act_d = 1'b0;
                end else begin
                    fb_d = fb_q + FB_W'(1);
                    sh_d = {sh_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
        shcp_d = act_d && (fb_d != FB_W'(FRAME_W)) && ph_d[1];
        stcp_d = act_d && (fb_d == FB_W'(FRAME_W));
    end

    // Shift engine registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            act_q  <= 1'b0;
            ph_q   <= 2'd0;
            fb_q   <= '0;
            sh_q   <= '0;
            shcp_q <= 1'b0;
            stcp_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            ph_q   <= ph_d;
            fb_q   <= fb_d;
            sh_q   <= sh_d;
            shcp_q <= shcp_d;
            stcp_q <= stcp_d;
        end
    end

    // Outputs stay disabled until the chain has been latched at least once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seen_q <= 1'b0;
            oe_q   <= 1'b1;
        end else begin
            seen_q <= seen_q | stcp_q;
            oe_q   <= ~(bus.seg_en & (seen_q | stcp_q));
        end
    end

    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign ds   = sh_q[FRAME_W-1];
    assign oe   = oe_q;

endmodule

// File: tb/tb_seg595_num_disp.sv
// tb_seg595_num_disp: directed bench for seg595_num_disp (DIG_NUM=6, DATA_W=20,
// SCAN_CNT=64, active-low segments). A monitor rebuilds each 595 frame from
// shcp/ds and files it by its select bit when stcp rises.
module tb_seg595_num_disp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic shcp, stcp, ds, oe;

    int n_checks = 0;
    int n_fail   = 0;

    seg595_num_disp_if #(.DIG_NUM(6), .DATA_W(20)) bus_if ();

    seg595_num_disp #(
        .DIG_NUM       (6),
        .DATA_W        (20),
        .SCAN_CNT      (64),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus_if.slave),
        .shcp   (shcp),
        .stcp   (stcp),
        .ds     (ds),
        .oe     (oe)
    );

    always #5 clk = ~clk;

    // Frame monitor
    logic [13:0] cap = '0;
    logic [13:0] frames [6];
    int          stcp_cnt  = 0;
    logic        shcp_prev = 1'b0;
    logic        stcp_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cap <= '0;
        end else begin
            if (shcp && !shcp_prev) cap <= {cap[12:0], ds};
            if (stcp && !stcp_prev) begin
                stcp_cnt <= stcp_cnt + 1;
                for (int k = 0; k < 6; k++) begin
                    if (cap[13:8] == 6'(1 << k)) frames[k] <= cap;
                end
            end
        end
        shcp_prev <= shcp;
        stcp_prev <= stcp;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle load; returns number of cycles busy was seen high
    task automatic load(input logic [19:0] d, input logic s, input logic [5:0] p,
                        output int busy_len);
        @(negedge clk);
        bus_if.data       = d;
        bus_if.sign       = s;
        bus_if.point      = p;
        bus_if.data_valid = 1'b1;
        @(negedge clk);
        bus_if.data_valid = 1'b0;
        busy_len = 0;
        for (int k = 0; k < 200; k++) begin
            if (!bus_if.busy) break;
            busy_len++;
            @(negedge clk);
        end
    endtask

    // Let every digit be rescanned, then compare frames; exp = {d5,...,d0}
    task automatic check_digits(input string tag, input logic [47:0] exp);
        logic [13:0] ef;
        repeat (520) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ef = {6'(1 << i), exp[8*i +: 8]};
            check_eq($sformatf("%s_d%0d", tag, i), {18'd0, frames[i]}, {18'd0, ef});
        end
    endtask

    int   blen;
    int   bad_oe;
    int   cnt0;
    logic found;

    initial begin
        bus_if.data       = '0;
        bus_if.sign       = 1'b0;
        bus_if.point      = '0;
        bus_if.seg_en     = 1'b0;
        bus_if.data_valid = 1'b0;
`ifdef SEG_BLINK_EN
        bus_if.blink      = '0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check_eq("rst_oe",   {31'd0, oe},   32'd1);
        check_eq("rst_shcp", {31'd0, shcp}, 32'd0);
        check_eq("rst_stcp", {31'd0, stcp}, 32'd0);
        check_eq("rst_ds",   {31'd0, ds},   32'd0);
        rst = 1'b0;

        // seg_en low: frames and latches keep going, outputs stay disabled
        cnt0   = stcp_cnt;
        bad_oe = 0;
        repeat (200) begin
            @(negedge clk);
            if (oe !== 1'b1) bad_oe++;
        end
        check_eq("oe_held_off", bad_oe, 0);
        check_eq("stcp_running", {31'd0, (stcp_cnt - cnt0) >= 3}, 32'd1);
        bus_if.seg_en = 1'b1;
        @(negedge clk);
        check_eq("oe_on", {31'd0, oe}, 32'd0);

        load(20'd123456, 1'b0, 6'b000000, blen);
        check_eq("busy_123456", blen, 21);
        check_digits("v123456", 48'hF9_A4_B0_99_92_82);

        load(20'd2575, 1'b1, 6'b000100, blen);
        check_eq("busy_2575", blen, 21);
        check_digits("v2575", 48'hFF_BF_A4_12_F8_92);

        // Seventh BCD digit nonzero
        load(20'd1048575, 1'b0, 6'b000000, blen);
        check_eq("busy_ovf7", blen, 21);
        check_digits("ovf7", 48'hBF_BF_BF_BF_BF_BF);

        load(20'd0, 1'b0, 6'b000000, blen);
        check_eq("busy_zero", blen, 21);
        check_digits("zero", 48'hFF_FF_FF_FF_FF_C0);

        // Six digits plus minus does not fit; dp suppressed too
        load(20'd999999, 1'b1, 6'b000001, blen);
        check_eq("busy_ovfs", blen, 21);
        check_digits("ovf_sign", 48'hBF_BF_BF_BF_BF_BF);

        // Point on the top digit forces leading zeros to be shown
        load(20'd7, 1'b0, 6'b100000, blen);
        check_eq("busy_pt", blen, 21);
        check_digits("pt_top", 48'h40_C0_C0_C0_C0_F8);

        // Second strobe while busy is dropped
        @(negedge clk);
        bus_if.data       = 20'd654321;
        bus_if.sign       = 1'b0;
        bus_if.point      = '0;
        bus_if.data_valid = 1'b1;
        @(negedge clk);
        bus_if.data_valid = 1'b0;
        blen = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == 3) begin
                bus_if.data       = 20'd111111;
                bus_if.data_valid = 1'b1;
            end
            if (k == 4) bus_if.data_valid = 1'b0;
            if (!bus_if.busy) break;
            blen++;
            @(negedge clk);
        end
        check_eq("busy_dbl", blen, 21);
        check_digits("dbl", 48'h82_92_99_B0_A4_F9);

        // Reset in the middle of a frame and of a conversion
        @(negedge clk);
        bus_if.data       = 20'd4321;
        bus_if.data_valid = 1'b1;
        @(negedge clk);
        bus_if.data_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (shcp && bus_if.busy) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("midframe_found", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_busy", {31'd0, bus_if.busy}, 32'd0);
        check_eq("mid_oe",   {31'd0, oe},   32'd1);
        check_eq("mid_shcp", {31'd0, shcp}, 32'd0);
        check_eq("mid_stcp", {31'd0, stcp}, 32'd0);
        check_eq("mid_ds",   {31'd0, ds},   32'd0);
        @(negedge clk);
        @(negedge clk);
        cnt0 = stcp_cnt;
        rst  = 1'b0;
        repeat (56) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("no_early_stcp", stcp_cnt - cnt0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("first_stcp", stcp_cnt - cnt0, 1);
        check_digits("blank", 48'hFF_FF_FF_FF_FF_FF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
